// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retirement trace buffer: trace-entry layout, drain FSM states and
// default sizing. Entry data fields are TrXlen wide, so the top-level XLEN must match it.
package retire_trace_buffer_pkg;

   localparam int unsigned TrDepth = 8;
   localparam int unsigned TrXlen  = 32;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StDrain = 2'd1,
      StDone  = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0]       seq;
      logic [TrXlen-1:0] pc;
      logic [31:0]       instr;
      logic [4:0]        rd;
      logic              rd_we;
      logic [TrXlen-1:0] rd_data;
      logic              mem_we;
      logic [TrXlen-1:0] mem_addr;
      logic [TrXlen-1:0] mem_data;
   } trace_entry_t;

endpackage

// File: rtl/retire_trace_buffer_trace_fifo.sv
// First-word-fall-through FIFO of trace entries; the head entry is visible the edge it is
// written. A push while full is accepted only when a pop happens on the same edge.
module trace_fifo
   import retire_trace_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = TrDepth,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  trace_entry_t data_i,
   input  logic         pop_i,
   output trace_entry_t data_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [CW-1:0] count_o
);

   trace_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   always_comb begin
      empty_o = (count_q == '0);
      full_o  = (count_q == CW'(DEPTH));
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);
      data_o  = mem_q[rd_ptr_q];
      count_o = count_q;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures retiring instructions into a trace FIFO with a sequence number, counts drops,
// and drains the remaining entries after a CPU halt.
module retire_trace_buffer
   import retire_trace_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = TrDepth,
   parameter int unsigned XLEN  = TrXlen,
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_valid_i,
   input  logic [XLEN-1:0] wb_pc_i,
   input  logic [31:0]     wb_instr_i,
   input  logic [4:0]      wb_rd_i,
   input  logic            wb_rd_we_i,
   input  logic [XLEN-1:0] wb_rd_data_i,
   input  logic            wb_mem_we_i,
   input  logic [XLEN-1:0] wb_mem_addr_i,
   input  logic [XLEN-1:0] wb_mem_data_i,
   input  logic            halt_in_i,
   output logic            tr_valid_o,
   input  logic            tr_ready_i,
   output logic [31:0]     tr_seq_o,
   output logic [XLEN-1:0] tr_pc_o,
   output logic [31:0]     tr_instr_o,
   output logic [4:0]      tr_rd_o,
   output logic            tr_rd_we_o,
   output logic [XLEN-1:0] tr_rd_data_o,
   output logic            tr_mem_we_o,
   output logic [XLEN-1:0] tr_mem_addr_o,
   output logic [XLEN-1:0] tr_mem_data_o,
   output logic            tr_last_o,
   output logic [CW-1:0]   count_o,
   output logic            overflow_o,
   output logic            drained_o
);

   state_e        state_q, state_d;
   logic [31:0]   seq_q, seq_d;
   logic          overflow_q, overflow_d;
   logic          in_run, push, pop;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count, count_next;
   trace_entry_t  wr_entry, rd_entry;

   always_comb begin
      in_run = (state_q == StRun);
      pop    = tr_ready_i & ~fifo_empty;
      push   = in_run & wb_valid_i & (~fifo_full | pop);

      wr_entry          = '0;
      wr_entry.seq      = seq_q;
      wr_entry.pc       = wb_pc_i;
      wr_entry.instr    = wb_instr_i;
      wr_entry.rd       = wb_rd_i;
      wr_entry.rd_we    = wb_rd_we_i & (wb_rd_i != 5'd0);
      wr_entry.rd_data  = wb_rd_data_i;
      wr_entry.mem_we   = wb_mem_we_i;
      wr_entry.mem_addr = wb_mem_addr_i;
      wr_entry.mem_data = wb_mem_data_i;

      // Sequence advances on every retirement seen in RUN, captured or dropped.
      seq_d      = (in_run & wb_valid_i) ? seq_q + 32'd1 : seq_q;
      overflow_d = overflow_q | (in_run & wb_valid_i & ~push);
      count_next = fifo_count + CW'(push) - CW'(pop);

      state_d = state_q;
      case (state_q)
         StRun:   if (halt_in_i) state_d = (count_next == '0) ? StDone : StDrain;
         StDrain: if (count_next == '0) state_d = StDone;
         StDone:  state_d = StDone;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StRun;
         seq_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (wr_entry),
      .pop_i   (pop),
      .data_o  (rd_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      tr_valid_o    = ~fifo_empty;
      tr_seq_o      = rd_entry.seq;
      tr_pc_o       = rd_entry.pc;
      tr_instr_o    = rd_entry.instr;
      tr_rd_o       = rd_entry.rd;
      tr_rd_we_o    = rd_entry.rd_we;
      tr_rd_data_o  = rd_entry.rd_data;
      tr_mem_we_o   = rd_entry.mem_we;
      tr_mem_addr_o = rd_entry.mem_addr;
      tr_mem_data_o = rd_entry.mem_data;
      tr_last_o     = (state_q == StDrain) && (fifo_count == CW'(1));
      count_o       = fifo_count;
      overflow_o    = overflow_q;
      drained_o     = (state_q == StDone);
   end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: a queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_retire_trace_buffer;

   localparam int DEPTH = 8;
   localparam int XLEN  = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk, rst;
   logic            wb_valid, wb_rd_we, wb_mem_we, halt_in, tr_ready;
   logic [XLEN-1:0] wb_pc, wb_rd_data, wb_mem_addr, wb_mem_data;
   logic [31:0]     wb_instr;
   logic [4:0]      wb_rd;
   logic            tr_valid, tr_rd_we, tr_mem_we, tr_last, overflow, drained;
   logic [31:0]     tr_seq, tr_instr;
   logic [XLEN-1:0] tr_pc, tr_rd_data, tr_mem_addr, tr_mem_data;
   logic [4:0]      tr_rd;
   logic [CW-1:0]   count;

   int errors = 0;
   int checks = 0;

   retire_trace_buffer #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wb_valid_i    (wb_valid),
      .wb_pc_i       (wb_pc),
      .wb_instr_i    (wb_instr),
      .wb_rd_i       (wb_rd),
      .wb_rd_we_i    (wb_rd_we),
      .wb_rd_data_i  (wb_rd_data),
      .wb_mem_we_i   (wb_mem_we),
      .wb_mem_addr_i (wb_mem_addr),
      .wb_mem_data_i (wb_mem_data),
      .halt_in_i     (halt_in),
      .tr_valid_o    (tr_valid),
      .tr_ready_i    (tr_ready),
      .tr_seq_o      (tr_seq),
      .tr_pc_o       (tr_pc),
      .tr_instr_o    (tr_instr),
      .tr_rd_o       (tr_rd),
      .tr_rd_we_o    (tr_rd_we),
      .tr_rd_data_o  (tr_rd_data),
      .tr_mem_we_o   (tr_mem_we),
      .tr_mem_addr_o (tr_mem_addr),
      .tr_mem_data_o (tr_mem_data),
      .tr_last_o     (tr_last),
      .count_o       (count),
      .overflow_o    (overflow),
      .drained_o     (drained)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of entries plus the halt/drain phase.
   typedef struct packed {
      logic [31:0] seq;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic        rd_we;
      logic [31:0] rd_data;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_data;
   } ent_t;

   localparam int PhRun = 0, PhDrain = 1, PhDone = 2;
   ent_t        mq[$];
   ent_t        m_new;
   logic [31:0] m_seq = '0;
   logic        m_ovf = 1'b0;
   int          m_ph  = PhRun;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_seq = '0;
         m_ovf = 1'b0;
         m_ph  = PhRun;
      end else begin
         if (mq.size() > 0 && tr_ready) void'(mq.pop_front());
         if (m_ph == PhRun && wb_valid) begin
            m_new = '{seq: m_seq, pc: wb_pc, instr: wb_instr, rd: wb_rd,
                      rd_we: wb_rd_we && (wb_rd != 0), rd_data: wb_rd_data,
                      mem_we: wb_mem_we, mem_addr: wb_mem_addr, mem_data: wb_mem_data};
            if (mq.size() < DEPTH) mq.push_back(m_new);
            else m_ovf = 1'b1;
            m_seq = m_seq + 1;
         end
         if (m_ph == PhRun && halt_in) m_ph = (mq.size() == 0) ? PhDone : PhDrain;
         else if (m_ph == PhDrain && mq.size() == 0) m_ph = PhDone;
      end
   end

   always @(negedge clk) begin
      chk("valid", 256'(tr_valid), 256'(mq.size() > 0));
      chk("count", 256'(count), 256'(mq.size()));
      chk("overflow", 256'(overflow), 256'(m_ovf));
      chk("drained", 256'(drained), 256'(m_ph == PhDone));
      chk("last", 256'(tr_last), 256'(m_ph == PhDrain && mq.size() == 1));
      if (mq.size() > 0)
         chk("head", 256'({tr_seq, tr_pc, tr_instr, tr_rd, tr_rd_we, tr_rd_data, tr_mem_we,
                           tr_mem_addr, tr_mem_data}), 256'(mq[0]));
   end

   task automatic idle();
      wb_valid = 1'b0; wb_pc = '0; wb_instr = '0; wb_rd = '0; wb_rd_we = 1'b0;
      wb_rd_data = '0; wb_mem_we = 1'b0; wb_mem_addr = '0; wb_mem_data = '0;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                         input logic rd_we, input logic [31:0] rd_data, input logic mem_we,
                         input logic [31:0] addr, input logic [31:0] data);
      wb_valid = 1'b1; wb_pc = pc; wb_instr = instr; wb_rd = rd; wb_rd_we = rd_we;
      wb_rd_data = rd_data; wb_mem_we = mem_we; wb_mem_addr = addr; wb_mem_data = data;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b0;
      idle();
      halt_in  = 1'b0;
      tr_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
   endtask

   // Retire n generic ALU ops, one per cycle; returns at negedge+1 with inputs idle.
   task automatic burst(input int n);
      for (int i = 0; i < n; i++) begin
         retire(32'h100 + 32'(4 * i), 32'h00208133, 5'd2, 1'b1, 32'(i), 1'b0, '0, '0);
         @(negedge clk);
         #1;
      end
      idle();
   endtask

   initial begin
      rst = 1'b0;
      idle();
      halt_in  = 1'b0;
      tr_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 256'(tr_valid), 256'(0));
      chk("rst_count", 256'(count), 256'(0));
      chk("rst_flags", 256'({overflow, drained, tr_last}), 256'(0));
      #1 rst = 1'b1;

      // Three retirements with the consumer always ready.
      tr_ready = 1'b1;
      retire(32'h0, 32'h00500093, 5'd1, 1'b1, 32'd5, 1'b0, '0, '0);
      @(negedge clk);
      chk("e0_seq", 256'(tr_seq), 256'(0));
      chk("e0_rd", 256'({tr_valid, tr_pc, tr_rd_we, tr_rd_data}), 256'({1'b1, 32'h0, 1'b1, 32'd5}));
      #1 retire(32'h4, 32'h00000033, 5'd0, 1'b1, 32'h1234, 1'b0, '0, '0);
      @(negedge clk);
      chk("e1_seq", 256'(tr_seq), 256'(1));
      chk("e1_x0", 256'(tr_rd_we), 256'(0));
      #1 retire(32'h8, 32'h00502823, 5'd0, 1'b0, '0, 1'b1, 32'h10, 32'd5);
      @(negedge clk);
      chk("e2_seq", 256'(tr_seq), 256'(2));
      chk("e2_mem", 256'({tr_mem_we, tr_mem_addr, tr_mem_data}), 256'({1'b1, 32'h10, 32'd5}));
      #1 idle();
      @(negedge clk);
      chk("e_empty", 256'(tr_valid), 256'(0));

      // Overflow: ten retirements into an eight-entry buffer.
      do_reset();
      burst(10);
      chk("ovf_count", 256'(count), 256'(8));
      chk("ovf_flag", 256'(overflow), 256'(1));
      tr_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("ovf_seq", 256'(tr_seq), 256'(i));
         @(negedge clk);
         #1;
      end
      chk("ovf_empty", 256'(tr_valid), 256'(0));
      burst(1);
      chk("ovf_next_seq", 256'(tr_seq), 256'(10));

      // Full buffer with simultaneous push and pop.
      do_reset();
      burst(8);
      chk("full_count", 256'(count), 256'(8));
      tr_ready = 1'b1;
      burst(1);
      tr_ready = 1'b0;
      chk("pp_count", 256'(count), 256'(8));
      chk("pp_ovf", 256'(overflow), 256'(0));
      chk("pp_head", 256'(tr_seq), 256'(1));

      // Halt with a simultaneous retirement, then drain.
      do_reset();
      burst(3);
      halt_in = 1'b1;
      burst(1);
      halt_in = 1'b0;
      chk("halt_count", 256'(count), 256'(4));
      chk("halt_last0", 256'({tr_last, drained}), 256'(0));
      tr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_last", 256'(tr_last), 256'(i == 3));
         chk("drain_seq", 256'(tr_seq), 256'(i));
         retire(32'hdead0000, 32'h00100093, 5'd1, 1'b1, 32'd1, 1'b0, '0, '0);
         @(negedge clk);
         #1;
      end
      idle();
      chk("drained", 256'({drained, tr_valid, count}), 256'({1'b1, 1'b0, 4'd0}));
      burst(2);
      chk("done_ignore", 256'({drained, tr_valid, count}), 256'({1'b1, 1'b0, 4'd0}));

      // Halt while empty.
      do_reset();
      halt_in = 1'b1;
      @(negedge clk);
      #1 halt_in = 1'b0;
      chk("halt_empty", 256'({drained, tr_valid}), 256'({1'b1, 1'b0}));

      // Asynchronous reset with entries buffered.
      do_reset();
      burst(5);
      chk("pre_rst_count", 256'(count), 256'(5));
      @(negedge clk);
      #3 rst = 1'b0;
      #1;
      chk("async_rst", 256'({tr_valid, count}), 256'({1'b0, 4'd0}));
      @(negedge clk);
      #1 rst = 1'b1;
      burst(1);
      chk("post_rst_seq", 256'({tr_valid, tr_seq}), 256'({1'b1, 32'd0}));

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
